pyramid_decimator: RTL

PYRAMID_DECIMATOR -- requirements
Module: pyramid_decimator

---
 rtl/pyramid_pkg.sv | 24 ++
 rtl/decim_line_buffer.sv | 43 ++++
 rtl/pyramid_decimator.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/pyramid_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pyramid_pkg
// Description : Shared constants and FSM state type for the 2x2 pyramid
//               decimator. Level-0 dimensions are the default source image
//               size; SUM_W is the width of a four-pixel sum.
// Revision    : 1.0 - initial release
// ============================================================================
package pyramid_pkg;

    localparam int PIX_W         = 8;
    localparam int SUM_W         = PIX_W + 2;
    localparam int LEVEL0_WIDTH  = 320;
    localparam int LEVEL0_HEIGHT = 240;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ROW_EVEN = 2'd1,
        ST_ROW_ODD  = 2'd2,
        ST_DONE     = 2'd3
    } decim_state_t;

endpackage : pyramid_pkg
`default_nettype wire

// File: rtl/decim_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : decim_line_buffer
// Description : Simple dual-port RAM holding one horizontal pair sum per
//               2-pixel column. Synchronous write, combinational read so the
//               odd-row sum is available in the same cycle as the pixel.
//               Contents are not reset; every entry is rewritten on each even
//               row before the following odd row reads it.
// Ports       : clk      - clock
//               wr_en    - write strobe
//               wr_addr  - write entry
//               wr_data  - pair sum to store
//               rd_addr  - read entry
//               rd_data  - stored pair sum (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module decim_line_buffer
    import pyramid_pkg::*;
#(
    parameter int DEPTH = LEVEL0_WIDTH / 2,
    parameter int WIDTH = PIX_W + 1,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule : decim_line_buffer
`default_nettype wire

// File: rtl/pyramid_decimator.sv
`default_nettype none
// ============================================================================
// Module      : pyramid_decimator
// Description : Builds one pyramid level by averaging every 2x2 block of a
//               raster-order source image. Even rows store horizontal pair
//               sums in a line buffer; odd rows complete the four-pixel sum
//               and issue one registered write per block.
// Ports       : clk, rst_n (async, active-low)
//               sof              - start of frame (restarts any frame)
//               pix_valid/data   - source pixel stream
//               pix_ready        - pixel accepted when valid & ready
//               wr_addr/data/en  - downsampled pixel write to frame memory
//               busy             - frame in progress
//               frame_done       - one-cycle pulse after the last write
// Config      : define PYRAMID_DECIM_ROUND_EN for round-to-nearest with
//               saturation; default build truncates (sum >> 2).
// Revision    : 1.0 - initial release
// ============================================================================
module pyramid_decimator
    import pyramid_pkg::*;
#(
    parameter int DATA_WIDTH = PIX_W,
    parameter int ADDR_WIDTH = 16,
    parameter int IMG_WIDTH  = LEVEL0_WIDTH,
    parameter int IMG_HEIGHT = LEVEL0_HEIGHT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sof,
    input  logic                  pix_valid,
    input  logic [DATA_WIDTH-1:0] pix_data,
    output logic                  pix_ready,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_en,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int c_XW       = $clog2(IMG_WIDTH);
    localparam int c_YW       = $clog2(IMG_HEIGHT);
    localparam int c_LB_DEPTH = IMG_WIDTH / 2;
    localparam int c_LB_AW    = (c_LB_DEPTH > 1) ? $clog2(c_LB_DEPTH) : 1;
    localparam int c_PAIR_W   = DATA_WIDTH + 1;
    localparam int c_SUM_W    = DATA_WIDTH + (SUM_W - PIX_W);

    localparam logic [c_XW-1:0] c_X_LAST = c_XW'(IMG_WIDTH - 1);
    localparam logic [c_YW-1:0] c_Y_LAST = c_YW'(IMG_HEIGHT - 1);

    decim_state_t          r_state;
    logic                  r_ready;
    logic                  r_busy;
    logic                  r_frame_done;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [ADDR_WIDTH-1:0] r_addr_cnt;
    logic [c_XW-1:0]       r_x;
    logic [c_YW-1:0]       r_y;
    logic [DATA_WIDTH-1:0] r_hold;

    logic                  w_accept;
    logic                  w_x_odd;
    logic                  w_x_last;
    logic                  w_y_last;
    logic                  w_lb_we;
    logic [c_LB_AW-1:0]    w_lb_addr;
    logic [c_PAIR_W-1:0]   w_pair;
    logic [c_PAIR_W-1:0]   w_lb_rd;
    logic [c_SUM_W-1:0]    w_sum;
    logic [DATA_WIDTH-1:0] w_avg;

    assign w_accept  = pix_valid & r_ready;
    assign w_x_odd   = r_x[0];
    assign w_x_last  = (r_x == c_X_LAST);
    assign w_y_last  = (r_y == c_Y_LAST);
    assign w_lb_addr = c_LB_AW'(r_x >> 1);
    assign w_pair    = c_PAIR_W'(r_hold) + c_PAIR_W'(pix_data);
    assign w_sum     = c_SUM_W'(w_lb_rd) + c_SUM_W'(r_hold) + c_SUM_W'(pix_data);

    // A restart request drops the coincident pixel, so it must not touch
    // the line buffer either.
    assign w_lb_we = w_accept & ~sof & (r_state == ST_ROW_EVEN) & w_x_odd;

`ifdef PYRAMID_DECIM_ROUND_EN
    logic [c_SUM_W:0] w_rnd;
    logic             w_sat;
    assign w_rnd = {1'b0, w_sum} + (c_SUM_W + 1)'(2);
    assign w_sat = |(w_rnd >> (DATA_WIDTH + 2));
    assign w_avg = w_sat ? {DATA_WIDTH{1'b1}} : DATA_WIDTH'(w_rnd >> 2);
`else
    assign w_avg = DATA_WIDTH'(w_sum >> 2);
`endif

    decim_line_buffer #(
        .DEPTH (c_LB_DEPTH),
        .WIDTH (c_PAIR_W),
        .AW    (c_LB_AW)
    ) u_line_buffer (
        .clk     (clk),
        .wr_en   (w_lb_we),
        .wr_addr (w_lb_addr),
        .wr_data (w_pair),
        .rd_addr (w_lb_addr),
        .rd_data (w_lb_rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_ready      <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_addr_cnt   <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_hold       <= '0;
        end else begin
            r_wr_en      <= 1'b0;
            r_frame_done <= 1'b0;
            if (sof) begin
                // Restart wins over everything; a frame that already reached
                // DONE has finished its writes and still reports completion.
                r_state      <= ST_ROW_EVEN;
                r_ready      <= 1'b1;
                r_busy       <= 1'b1;
                r_frame_done <= (r_state == ST_DONE);
                r_addr_cnt   <= '0;
                r_x          <= '0;
                r_y          <= '0;
            end else begin
                case (r_state)
                    ST_ROW_EVEN, ST_ROW_ODD: begin
                        if (w_accept) begin
                            if (!w_x_odd) begin
                                r_hold <= pix_data;
                            end
                            if ((r_state == ST_ROW_ODD) && w_x_odd) begin
                                r_wr_en    <= 1'b1;
                                r_wr_data  <= w_avg;
                                r_wr_addr  <= r_addr_cnt;
                                r_addr_cnt <= r_addr_cnt + ADDR_WIDTH'(1);
                            end
                            if (w_x_last) begin
                                r_x <= '0;
                                r_y <= w_y_last ? '0 : r_y + c_YW'(1);
                                if (r_state == ST_ROW_EVEN) begin
                                    r_state <= ST_ROW_ODD;
                                end else if (w_y_last) begin
                                    r_state <= ST_DONE;
                                    r_ready <= 1'b0;
                                end else begin
                                    r_state <= ST_ROW_EVEN;
                                end
                            end else begin
                                r_x <= r_x + c_XW'(1);
                            end
                        end
                    end
                    ST_DONE: begin
                        r_state      <= ST_IDLE;
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign pix_ready  = r_ready;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;

endmodule : pyramid_decimator
`default_nettype wire
